// File: rtl/mult_seq_arb.sv
// Two-requester round-robin front end to an iterative shift-add multiplier.
// Define MULT_SEQ_EARLY_TERM_EN to stop iterating once the remaining multiplier bits are zero.
module mult_seq_arb #(
    parameter int N = 4,
    parameter int M = 4
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           req0_vld,
    output logic           req0_rdy,
    input  logic [N-1:0]   req0_a,
    input  logic [M-1:0]   req0_b,
    input  logic           req1_vld,
    output logic           req1_rdy,
    input  logic [N-1:0]   req1_a,
    input  logic [M-1:0]   req1_b,
    output logic           res_vld,
    input  logic           res_rdy,
    output logic           res_id,
    output logic [N+M-1:0] res_data,
    output logic           busy
);
    localparam int W  = N + M;
    localparam int CW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state;
    logic [W-1:0]  mcand;
    logic [W-1:0]  acc;
    logic [W-1:0]  acc_next;
    logic [M-1:0]  mplier;
    logic [M-1:0]  mplier_next;
    logic [CW-1:0] cnt;
    logic          id;
    logic          last_grant;
    logic          grant0;
    logic          grant1;
    logic          xfer;
    logic          xfer_id;
    logic [N-1:0]  xfer_a;
    logic [M-1:0]  xfer_b;
    logic          last_iter;

    // On a tie the requester that did not win last time is granted.
    assign grant0   = req0_vld & (~req1_vld | last_grant);
    assign grant1   = req1_vld & (~req0_vld | ~last_grant);
    assign req0_rdy = (state == IDLE) & grant0;
    assign req1_rdy = (state == IDLE) & grant1;
    assign xfer     = req0_rdy | req1_rdy;
    assign xfer_id  = req1_rdy;
    assign xfer_a   = xfer_id ? req1_a : req0_a;
    assign xfer_b   = xfer_id ? req1_b : req0_b;
    assign busy     = (state != IDLE);

    assign mplier_next = mplier >> 1;

    always_comb begin
        // NOTE: default assignment first, so no path through this block can infer a latch.
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

`ifdef MULT_SEQ_EARLY_TERM_EN
    assign last_iter = (cnt == CW'(M - 1)) || (mplier_next == '0);
`else
    assign last_iter = (cnt == CW'(M - 1));
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            cnt        <= '0;
            id         <= 1'b0;
            last_grant <= 1'b1;
            res_vld    <= 1'b0;
            res_id     <= 1'b0;
            res_data   <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every read below sees the pre-edge value.
            case (state)
                IDLE: begin
                    if (xfer) begin
                        last_grant <= xfer_id;
                        id         <= xfer_id;
                        mcand      <= W'(xfer_a);
                        mplier     <= xfer_b;
                        acc        <= '0;
                        cnt        <= '0;
`ifdef MULT_SEQ_EARLY_TERM_EN
                        if (xfer_b == '0) begin
                            state    <= DONE;
                            res_vld  <= 1'b1;
                            res_data <= '0;
                            res_id   <= xfer_id;
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier_next;
                    cnt    <= cnt + CW'(1);
                    // The final accumulate is published directly into the result register.
                    if (last_iter) begin
                        state    <= DONE;
                        res_vld  <= 1'b1;
                        res_data <= acc_next;
                        res_id   <= id;
                    end
                end
                DONE: begin
                    if (res_rdy) begin
                        state   <= IDLE;
                        res_vld <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_seq_arb.sv
// Self-checking bench for mult_seq_arb: directed literal cases plus a random soak
// compared every cycle against a transaction-level model.
module tb_mult_seq_arb;
    localparam int N = 4;
    localparam int M = 4;
    localparam int W = N + M;

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic         req0_vld = 1'b0;
    logic         req1_vld = 1'b0;
    logic [N-1:0] req0_a = '0;
    logic [N-1:0] req1_a = '0;
    logic [M-1:0] req0_b = '0;
    logic [M-1:0] req1_b = '0;
    logic         res_rdy = 1'b0;
    logic         req0_rdy;
    logic         req1_rdy;
    logic         res_vld;
    logic         res_id;
    logic [W-1:0] res_data;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_seq_arb #(.N(N), .M(M)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req0_vld (req0_vld),
        .req0_rdy (req0_rdy),
        .req0_a   (req0_a),
        .req0_b   (req0_b),
        .req1_vld (req1_vld),
        .req1_rdy (req1_rdy),
        .req1_a   (req1_a),
        .req1_b   (req1_b),
        .res_vld  (res_vld),
        .res_rdy  (res_rdy),
        .res_id   (res_id),
        .res_data (res_data),
        .busy     (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: idle / computing for a number of cycles / presenting a result.
    bit           m_idle = 1'b1;
    bit           m_done = 1'b0;
    bit           m_last = 1'b1;
    bit           m_id = 1'b0;
    int           m_left = 0;
    logic [W-1:0] m_prod = '0;
    int           m_accepted = 0;
    int           m_aborted = 0;

    function automatic int calc_cycles(input logic [M-1:0] b);
`ifdef MULT_SEQ_EARLY_TERM_EN
        int n = 0;
        for (int i = 0; i < M; i++) if (b[i]) n = i + 1;
        return n;
`else
        return M;
`endif
    endfunction

    function automatic bit exp_rdy0();
        return m_idle && req0_vld && (!req1_vld || m_last);
    endfunction

    function automatic bit exp_rdy1();
        return m_idle && req1_vld && (!req0_vld || !m_last);
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            if (!m_idle) m_aborted++;
            m_idle = 1'b1;
            m_done = 1'b0;
            m_last = 1'b1;
            m_id   = 1'b0;
            m_left = 0;
            m_prod = '0;
        end else if (m_done) begin
            if (res_rdy) begin
                m_done = 1'b0;
                m_idle = 1'b1;
            end
        end else if (!m_idle) begin
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end else if (exp_rdy0() || exp_rdy1()) begin
            m_id   = exp_rdy1();
            m_last = m_id;
            m_idle = 1'b0;
            m_prod = m_id ? W'(req1_a) * W'(req1_b) : W'(req0_a) * W'(req0_b);
            m_left = calc_cycles(m_id ? req1_b : req0_b);
            m_accepted++;
            if (m_left == 0) m_done = 1'b1;
        end
    end

    // Per-cycle compare plus bookkeeping used to sequence the directed tests.
    int           cyc = 0;
    int           n_xfer = 0;
    int           n_res = 0;
    int           xfer_cyc = 0;
    int           last_lat = 0;
    bit           last_xfer_id = 1'b0;
    logic [W-1:0] last_data = '0;
    bit           last_id = 1'b0;
    bit           prev_vld = 1'b0;

    always begin
        @(negedge clk);
        #1;
        cyc++;
        check("req0_rdy", req0_rdy, exp_rdy0());
        check("req1_rdy", req1_rdy, exp_rdy1());
        check("busy", busy, !m_idle);
        check("res_vld", res_vld, m_done);
        if (m_done) begin
            check("res_id", res_id, m_id);
            check("res_data", res_data, m_prod);
        end
        if ((req0_vld && req0_rdy) || (req1_vld && req1_rdy)) begin
            n_xfer++;
            xfer_cyc     = cyc;
            last_xfer_id = req1_vld && req1_rdy;
        end
        if (res_vld && !prev_vld) last_lat = cyc - xfer_cyc;
        prev_vld = res_vld;
        if (res_vld && res_rdy) begin
            n_res++;
            last_data = res_data;
            last_id   = res_id;
        end
    end

    task automatic wait_xfer(input int n0, input string name);
        int i = 0;
        while (n_xfer == n0 && i < 100) begin
            @(negedge clk);
            i++;
        end
        check(name, n_xfer == n0, 0);
    endtask

    task automatic wait_res(input int n0, input string name);
        int i = 0;
        while (n_res == n0 && i < 100) begin
            @(negedge clk);
            i++;
        end
        check(name, n_res == n0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req0_vld = 1'b0;
        req1_vld = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic run_req0(input logic [N-1:0] a, input logic [M-1:0] b);
        int nx;
        int nr;
        @(negedge clk);
        res_rdy  = 1'b1;
        req0_vld = 1'b1;
        req0_a   = a;
        req0_b   = b;
        nx = n_xfer;
        nr = n_res;
        wait_xfer(nx, "req0 accept timeout");
        req0_vld = 1'b0;
        wait_res(nr, "req0 result timeout");
    endtask

    // Both requesters raise vld together; req0 must win, then req1 follows.
    task automatic tie_pair(input logic [N-1:0] a0, input logic [M-1:0] b0,
                            input logic [N-1:0] a1, input logic [M-1:0] b1,
                            input logic [W-1:0] e0, input logic [W-1:0] e1);
        int nx;
        int nr;
        @(negedge clk);
        res_rdy  = 1'b1;
        req0_vld = 1'b1;
        req0_a   = a0;
        req0_b   = b0;
        req1_vld = 1'b1;
        req1_a   = a1;
        req1_b   = b1;
        nx = n_xfer;
        nr = n_res;
        wait_xfer(nx, "tie first accept timeout");
        check("tie first grant", last_xfer_id, 0);
        req0_vld = 1'b0;
        wait_res(nr, "tie first result timeout");
        check("tie first data", last_data, e0);
        check("tie first id", last_id, 0);
        nx = n_xfer;
        nr = n_res;
        wait_xfer(nx, "tie second accept timeout");
        check("tie second grant", last_xfer_id, 1);
        req1_vld = 1'b0;
        wait_res(nr, "tie second result timeout");
        check("tie second data", last_data, e1);
        check("tie second id", last_id, 1);
    endtask

    initial begin
        int nx;
        int nr;
        int i;
        int base;

        #1 rstn = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check("reset res_vld", res_vld, 0);
        check("reset res_data", res_data, 0);
        check("reset res_id", res_id, 0);
        check("reset busy", busy, 0);
        @(negedge clk);
        rstn = 1'b1;

        run_req0(4'd15, 4'd15);
        check("single data", last_data, 8'hE1);
        check("single id", last_id, 0);
        check("single latency", last_lat, M + 1);

        do_reset();
        tie_pair(4'd3, 4'd5, 4'd7, 4'd2, 8'd15, 8'd14);
        tie_pair(4'd6, 4'd6, 4'd1, 4'd9, 8'd36, 8'd9);

        // Backpressure: result must hold steady and nobody may be accepted.
        @(negedge clk);
        res_rdy  = 1'b0;
        req0_vld = 1'b1;
        req0_a   = 4'd9;
        req0_b   = 4'd13;
        nx = n_xfer;
        wait_xfer(nx, "bp accept timeout");
        req0_vld = 1'b0;
        i = 0;
        while (!res_vld && i < 20) begin
            @(negedge clk);
            i++;
        end
        check("bp result timeout", res_vld, 1);
        req0_vld = 1'b1;
        req1_vld = 1'b1;
        repeat (10) begin
            @(negedge clk);
            #2;
            check("bp res_vld", res_vld, 1);
            check("bp res_data", res_data, 8'h75);
            check("bp res_id", res_id, 0);
            check("bp req0_rdy", req0_rdy, 0);
            check("bp req1_rdy", req1_rdy, 0);
        end
        @(negedge clk);
        res_rdy = 1'b1;
        #2;
        check("bp take req0_rdy", req0_rdy, 0);
        check("bp take req1_rdy", req1_rdy, 0);
        @(negedge clk);
        req0_vld = 1'b0;
        req1_vld = 1'b0;
        #2;
        check("bp idle busy", busy, 0);
        check("bp idle res_vld", res_vld, 0);

        run_req0(4'd0, 4'd9);
        check("zero a data", last_data, 0);
        check("zero a latency", last_lat, M + 1);
        run_req0(4'd12, 4'd0);
        check("zero b data", last_data, 0);
`ifdef MULT_SEQ_EARLY_TERM_EN
        check("zero b latency", last_lat, 1);
`else
        check("zero b latency", last_lat, M + 1);
`endif
        run_req0(4'd7, 4'd1);
        check("b one data", last_data, 7);
`ifndef MULT_SEQ_EARLY_TERM_EN
        check("b one latency", last_lat, M + 1);
`endif

        // Reset in the middle of an iteration, then a normal tie.
        @(negedge clk);
        res_rdy  = 1'b1;
        req0_vld = 1'b1;
        req0_a   = 4'd13;
        req0_b   = 4'd11;
        nx = n_xfer;
        nr = n_res;
        wait_xfer(nx, "abort accept timeout");
        req0_vld = 1'b0;
        repeat (2) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        check("abort res_vld", res_vld, 0);
        check("abort res_data", res_data, 0);
        check("abort res_id", res_id, 0);
        check("abort busy", busy, 0);
        @(negedge clk);
        rstn = 1'b1;
        check("abort no result", n_res, nr);
        tie_pair(4'd2, 4'd3, 4'd5, 4'd5, 8'd6, 8'd25);

        // Random soak on both ports with random backpressure.
        base = n_res;
        i = 0;
        while ((n_res - base) < 1000 && i < 40000) begin
            @(negedge clk);
            req0_vld = 1'($urandom_range(0, 1));
            req1_vld = 1'($urandom_range(0, 1));
            req0_a   = N'($urandom);
            req0_b   = M'($urandom);
            req1_a   = N'($urandom);
            req1_b   = M'($urandom);
            res_rdy  = ($urandom_range(0, 3) != 0);
            i++;
        end
        check("soak timeout", (n_res - base) >= 1000, 1);

        @(negedge clk);
        req0_vld = 1'b0;
        req1_vld = 1'b0;
        res_rdy  = 1'b1;
        i = 0;
        while (!m_idle && i < 50) begin
            @(negedge clk);
            i++;
        end
        @(negedge clk);
        #2;
        check("drain idle", busy, 0);
        check("accept count", n_xfer, m_accepted);
        check("result count", n_res, m_accepted - m_aborted);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
